// File: rtl/timer_ctrl.sv
// Command-driven run/pause/expire controller for a W-bit up-counter.
// Accepts START/PAUSE/RESUME/ABORT, exports the count and pulses done/cmd_err.
module timer_ctrl #(
    parameter int W      = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [W-1:0]      cmd_limit,
    input  logic              cmd_periodic,
    output logic [W-1:0]      count,
    output logic              busy,
    output logic              done,
    output logic              cmd_err,
    output logic [WRAP_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] OP_START  = 2'd0;
    localparam logic [1:0] OP_PAUSE  = 2'd1;
    localparam logic [1:0] OP_RESUME = 2'd2;
    localparam logic [1:0] OP_ABORT  = 2'd3;

    state_t              state_q, state_d;
    logic [W-1:0]        count_q, count_d;
    logic [W-1:0]        limit_q, limit_d;
    logic                periodic_q, periodic_d;
    logic [WRAP_W-1:0]   wrap_q, wrap_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                accept_s;
    logic                terminal_s;

    // Ready drops asynchronously with reset and for the single DONE cycle.
    assign cmd_ready  = rst_n & (state_q != S_DONE);
    assign accept_s   = cmd_valid & cmd_ready;
    assign terminal_s = (count_q == limit_q);

    // Next-state, datapath and pulse computation.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        limit_d    = limit_q;
        periodic_d = periodic_q;
        wrap_d     = wrap_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s && (cmd_op == OP_START)) begin
                    state_d    = S_RUN;
                    count_d    = {W{1'b0}};
                    limit_d    = cmd_limit;
                    periodic_d = cmd_periodic;
                    wrap_d     = {WRAP_W{1'b0}};
                end else if (accept_s && (cmd_op != OP_ABORT)) begin
                    err_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept_s && (cmd_op == OP_ABORT)) begin
                    // Abort beats a coincident expiry: no done pulse.
                    state_d = S_IDLE;
                    count_d = {W{1'b0}};
                end else if (terminal_s) begin
                    count_d = {W{1'b0}};
                    done_d  = 1'b1;
                    err_d   = accept_s && ((cmd_op != OP_PAUSE) || !periodic_q);
                    if (periodic_q) begin
                        wrap_d  = (wrap_q == {WRAP_W{1'b1}}) ? wrap_q : wrap_q + WRAP_W'(1);
                        state_d = (accept_s && (cmd_op == OP_PAUSE)) ? S_PAUSED : S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (accept_s && (cmd_op == OP_PAUSE)) begin
                    state_d = S_PAUSED;
                end else begin
                    count_d = count_q + W'(1);
                    err_d   = accept_s;
                end
            end
            S_PAUSED: begin
                if (accept_s && (cmd_op == OP_RESUME)) begin
                    state_d = S_RUN;
                end else if (accept_s && (cmd_op == OP_ABORT)) begin
                    state_d = S_IDLE;
                    count_d = {W{1'b0}};
                end else begin
                    err_d = accept_s;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                count_d = {W{1'b0}};
            end
            default: begin
                state_d = S_IDLE;
                count_d = {W{1'b0}};
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_PAUSED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= {W{1'b0}};
            limit_q    <= {W{1'b0}};
            periodic_q <= 1'b0;
            wrap_q     <= {WRAP_W{1'b0}};
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            limit_q    <= limit_d;
            periodic_q <= periodic_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign count    = count_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cmd_err  = err_q;
    assign wrap_cnt = wrap_q;

endmodule
